// File: rtl/rsa_pkg.sv
// RSA exponentiation sequencer shared types.
// Controller states, op sub-phases and operand select codes.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EXP,
    POST,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_RST,
    PH_LD,
    PH_RUN
  } phase_t;

  localparam logic [1:0] SEL1_INIT = 2'd0;
  localparam logic [1:0] SEL1_MUL  = 2'd1;
  localparam logic [1:0] SEL1_POST = 2'd2;

  localparam logic SEL2_INIT = 1'b0;
  localparam logic SEL2_SQR  = 1'b1;

endpackage

// File: rtl/rsa_exp_sequencer_if.sv
// Host launch handshake plus Montgomery multiplier control bundle.
// master = host/datapath side, slave = sequencer side.
interface rsa_exp_sequencer_if #(
  parameter int WIDTH = 10
) ();

  logic             start;
  logic [WIDTH-1:0] expE;
  logic             rst_mmm;
  logic             ld_a;
  logic             ld_r;
  logic             lock1;
  logic             lock2;
  logic [1:0]       sel1;
  logic             sel2;
  logic             busy;
  logic             eoc;

  modport master (
    output start, expE,
    input  rst_mmm, ld_a, ld_r,
    input  lock1, lock2, sel1, sel2,
    input  busy, eoc
  );

  modport slave (
    input  start, expE,
    output rst_mmm, ld_a, ld_r,
    output lock1, lock2, sel1, sel2,
    output busy, eoc
  );

endinterface

// File: rtl/rsa_op_timer.sv
// RST -> LD -> RUN sub-phase generator for one multiplier op.
// Advances only on enabled cycles while the controller is inside an op.
module rsa_op_timer
  import rsa_pkg::*;
#(
  parameter int MMM_CYCLES = 10
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic run,
  output logic rst_stb,
  output logic ld_stb,
  output logic op_done
);

  localparam int CW = (MMM_CYCLES > 1) ? $clog2(MMM_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MMM_CYCLES - 1);

  phase_t        ph;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ph  <= PH_RST;
      cnt <= '0;
    end else if (ena && run) begin
      unique case (ph)
        PH_RST: ph <= PH_LD;
        PH_LD: begin
          ph  <= PH_RUN;
          cnt <= '0;
        end
        PH_RUN: begin
          if (cnt == LAST) begin
            ph  <= PH_RST;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ph <= PH_RST;
      endcase
    end
  end

  // ena masks the strobes so a frozen sub-phase is seen exactly once
  assign rst_stb = ena & run & (ph == PH_RST);
  assign ld_stb  = ena & run & (ph == PH_LD);
  assign op_done = ena & run & (ph == PH_RUN) & (cnt == LAST);

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Right-to-left binary exponentiation sequencer for two
// Montgomery multipliers (multiply unit R, square unit P_i).
module rsa_exp_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int MMM_CYCLES = 10
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  rsa_exp_sequencer_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_nx;
  logic             run;
  logic             rst_stb;
  logic             ld_stb;
  logic             op_done;
  logic             eoc_q;
  logic             busy_q;
  logic             lock1_q;
  logic             lock2_q;
  logic [1:0]       sel1_q;
  logic             sel2_q;

  assign run  = (state == INIT) | (state == EXP) | (state == POST);
  assign s_nx = s >> 1;

  rsa_op_timer #(
    .MMM_CYCLES(MMM_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rstb   (rstb),
    .ena    (ena),
    .run    (run),
    .rst_stb(rst_stb),
    .ld_stb (ld_stb),
    .op_done(op_done)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      s       <= '0;
      busy_q  <= 1'b0;
      eoc_q   <= 1'b0;
      lock1_q <= 1'b1;
      lock2_q <= 1'b1;
      sel1_q  <= SEL1_INIT;
      sel2_q  <= SEL2_INIT;
    end else if (ena) begin
      eoc_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            s       <= bus.expE;
            state   <= INIT;
            busy_q  <= 1'b1;
            sel1_q  <= SEL1_INIT;
            sel2_q  <= SEL2_INIT;
            lock1_q <= 1'b0;
            lock2_q <= 1'b0;
          end
        end
        INIT: begin
          if (op_done) begin
            if (s != '0) begin
              state   <= EXP;
              sel1_q  <= SEL1_MUL;
              sel2_q  <= SEL2_SQR;
              lock1_q <= ~s[0];
              lock2_q <= 1'b0;
            end else begin
              state   <= POST;
              sel1_q  <= SEL1_POST;
              lock1_q <= 1'b0;
              lock2_q <= 1'b1;
            end
          end
        end
        EXP: begin
          if (op_done) begin
            s <= s_nx;
            if (s_nx != '0) begin
              lock1_q <= ~s_nx[0];
            end else begin
              state   <= POST;
              sel1_q  <= SEL1_POST;
              lock1_q <= 1'b0;
              lock2_q <= 1'b1;
            end
          end
        end
        POST: begin
          if (op_done) begin
            state   <= DONE;
            eoc_q   <= 1'b1;
            lock1_q <= 1'b1;
            lock2_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rst_mmm = rst_stb;
  assign bus.ld_a    = ld_stb;
  assign bus.ld_r    = ld_stb;
  assign bus.eoc     = eoc_q & ena;
  assign bus.busy    = busy_q;
  assign bus.lock1   = lock1_q;
  assign bus.lock2   = lock2_q;
  assign bus.sel1    = sel1_q;
  assign bus.sel2    = sel2_q;

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Randomized bench for rsa_exp_sequencer with a modular-arithmetic
// datapath model driven from the observed control strobes.
module tb_rsa_exp_sequencer;

  localparam int W   = 10;
  localparam int MC  = 10;
  localparam int OPC = MC + 2;
  localparam int MOD = 13;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  logic ena  = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  rsa_exp_sequencer_if #(.WIDTH(W)) bus ();

  rsa_exp_sequencer #(
    .WIDTH     (W),
    .MMM_CYCLES(MC)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return {22'd0, bus.rst_mmm, bus.ld_a, bus.ld_r, bus.eoc, bus.busy,
            bus.lock1, bus.lock2, bus.sel1, bus.sel2};
  endfunction

  // lock1=1, lock2=1, everything else 0
  localparam int RST_OUTS = 24;

  function automatic int pow_mod(input int p, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * p) % MOD;
    return r;
  endfunction

  task automatic do_reset();
    bus.start = 1'b0;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic run_exp(input int e, input int p, input int gap_at,
                         input int gap_len, input int mid_at,
                         input int mid_e, input bit hold);
    logic [W-1:0] ev;
    logic [15:0]  seq_exp, seq_got;
    logic [5:0]   rec;
    int k, n_ops, lat, g;
    int eoc_at, n_eoc, n_busy, n_rst, n_ld, ctl_bad;
    int r, pi, nr, np;
    int busy_l1, busy_l2;
    ev = W'(e);
    k = -1;
    for (int i = 0; i < W; i++) if (ev[i]) k = i;
    n_ops = (k < 0) ? 2 : k + 3;
    lat = n_ops * OPC + 1 + gap_len;
    g = gap_at;
    if (gap_len > 0 && g == 0) g = $urandom_range(1, lat - gap_len - 1);
    seq_exp = '0;
    for (int i = 0; i <= k; i++) seq_exp[i + 1] = ~ev[i];
    seq_got = '0;
    rec = '0;
    eoc_at = 0; n_eoc = 0; n_busy = 0; n_rst = 0; n_ld = 0; ctl_bad = 0;
    r = 0; pi = 0; busy_l1 = -1; busy_l2 = -1;

    @(negedge clk);
    ena = 1'b1;
    bus.start = 1'b1;
    bus.expE = ev;
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && !hold) bus.start = 1'b0;
      if (cyc <= lat && bus.busy) n_busy++;
      if (cyc == lat + 1) busy_l1 = bus.busy;
      if (cyc == lat + 2) busy_l2 = bus.busy;
      if (cyc <= lat + 1 && bus.eoc) n_eoc++;
      if (eoc_at == 0) begin
        if (bus.ld_a != bus.ld_r || bus.sel1 == 2'd3) ctl_bad++;
        if (bus.rst_mmm) begin
          n_rst++;
          rec = {bus.sel1, bus.sel2, bus.lock1, bus.lock2, 1'b1};
        end
        if (bus.ld_a) begin
          n_ld++;
          if ({bus.sel1, bus.sel2, bus.lock1, bus.lock2, 1'b1} != rec)
            ctl_bad++;
          if (n_ld <= 16) seq_got[n_ld - 1] = bus.lock1;
          nr = r;
          np = pi;
          if (!bus.lock1) begin
            case (bus.sel1)
              2'd0:    nr = 1;
              2'd1:    nr = (r * pi) % MOD;
              default: nr = r;
            endcase
          end
          if (!bus.lock2) np = bus.sel2 ? (pi * pi) % MOD : p;
          r = nr;
          pi = np;
        end
        if (bus.eoc) eoc_at = cyc;
      end
      if (gap_len > 0 && cyc == g) ena = 1'b0;
      if (gap_len > 0 && cyc == g + gap_len) ena = 1'b1;
      if (mid_at > 0 && cyc == mid_at) begin
        bus.start = 1'b1;
        bus.expE = W'(mid_e);
      end
      if (mid_at > 0 && cyc == mid_at + 1) bus.start = 1'b0;
    end
    chk("eoc_cycle", eoc_at, lat);
    chk("eoc_count", n_eoc, 1);
    chk("busy_cycles", n_busy, lat);
    chk("busy_after_eoc", busy_l1, 0);
    chk("busy_restart", busy_l2, int'(hold));
    chk("rst_pulses", n_rst, n_ops);
    chk("ld_pulses", n_ld, n_ops);
    chk("ctl_stable", ctl_bad, 0);
    chk("lock1_seq", int'(seq_got), int'(seq_exp));
    chk("result", r, pow_mod(p, e));
  endtask

  task automatic abort_run(input int e, input int abort_at);
    int n_eoc = 0;
    int n_busy = 0;
    @(negedge clk);
    ena = 1'b1;
    bus.start = 1'b1;
    bus.expE = W'(e);
    for (int cyc = 1; cyc <= abort_at; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.eoc) n_eoc++;
    end
    rstb = 1'b0;
    #1;
    chk("abort_outs", outs(), RST_OUTS);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.eoc) n_eoc++;
      if (bus.busy) n_busy++;
    end
    chk("abort_no_eoc", n_eoc, 0);
    chk("abort_idle", n_busy, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.expE = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), RST_OUTS);
    rstb = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), RST_OUTS);

    run_exp(0, 7, 0, 0, 0, 0, 1'b0);
    run_exp(11, 3, 0, 0, 0, 0, 1'b0);
    run_exp('h200, 5, 0, 0, 0, 0, 1'b0);
    run_exp(11, 6, 26, 3, 0, 0, 1'b0);
    run_exp(11, 4, 0, 0, 30, 'h3FF, 1'b0);
    abort_run(11, 55);
    run_exp(1, 9, 0, 0, 0, 0, 1'b0);
    run_exp(5, 2, 0, 0, 0, 0, 1'b1);
    do_reset();

    for (int t = 0; t < 10; t++) begin
      int e, p, len;
      e = int'($urandom & ((32'd1 << $urandom_range(1, W)) - 1));
      p = $urandom_range(2, MOD - 1);
      len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      run_exp(e, p, 0, len, 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
